// File: rtl/mpu_ip_fetch.sv
// mpu_ip_fetch: instruction-pointer owner and fetch sequencer (IDLE/REQ/WAIT/HOLD).
// Rev 1.0
`default_nettype none

module mpu_ip_fetch #(
  parameter logic [15:0] RESET_IP     = 16'h0000,
  parameter int          RETIRE_WIDTH = 32
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    ctl_start,
  input  logic                    ctl_stop,
  input  logic                    ctl_ip_sel,
  input  logic [15:0]             ctl_ip,
  input  logic                    ip_en,
  input  logic [15:0]             ip_incr,
  input  logic                    ip_load,
  input  logic [15:0]             ip_data,
  output logic                    mem_re,
  output logic [15:0]             mem_addr,
  input  logic                    mem_ack,
  input  logic [63:0]             mem_data,
  output logic                    inst_valid,
  output logic [63:0]             inst,
  output logic [15:0]             inst_ip,
  output logic                    running,
  output logic                    err_spurious,
  output logic [RETIRE_WIDTH-1:0] retired
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             ip_q, ip_d;
  logic                    mem_re_q, mem_re_d;
  logic [15:0]             mem_addr_q, mem_addr_d;
  logic                    inst_valid_q, inst_valid_d;
  logic [63:0]             inst_q, inst_d;
  logic [15:0]             inst_ip_q, inst_ip_d;
  logic                    running_q, running_d;
  logic                    err_q, err_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic                    stop_pending_q, stop_pending_d;
  logic [15:0]             w_ip_next;
  logic [15:0]             w_start_ip;

  assign w_ip_next  = ip_load ? ip_data : ip_q + ip_incr;
  assign w_start_ip = ctl_ip_sel ? ctl_ip : RESET_IP;

  always_comb begin
    state_d        = state_q;
    ip_d           = ip_q;
    mem_re_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    inst_valid_d   = inst_valid_q;
    inst_d         = inst_q;
    inst_ip_d      = inst_ip_q;
    err_d          = err_q;
    retired_d      = retired_q;
    stop_pending_d = stop_pending_q;

    case (state_q)
      S_IDLE: begin
        if (ctl_start) begin
          state_d        = S_REQ;
          ip_d           = w_start_ip;
          mem_re_d       = 1'b1;
          mem_addr_d     = w_start_ip;
          err_d          = 1'b0;
          retired_d      = '0;
          stop_pending_d = ctl_stop;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (ctl_stop) stop_pending_d = 1'b1;
      end
      S_WAIT: begin
        if (ctl_stop) stop_pending_d = 1'b1;
        if (mem_ack) begin
          inst_d       = mem_data;
          inst_ip_d    = ip_q;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      default: begin
        if (ip_en) begin
          ip_d         = w_ip_next;
          inst_valid_d = 1'b0;
          if (~&retired_q) retired_d = retired_q + RETIRE_WIDTH'(1);
          if (stop_pending_q || ctl_stop) begin
            state_d        = S_IDLE;
            stop_pending_d = 1'b0;
          end else begin
            state_d    = S_REQ;
            mem_re_d   = 1'b1;
            mem_addr_d = w_ip_next;
          end
        end
      end
    endcase

    // A spurious commit outranks the clear that a same-cycle start performs.
    if (ip_en && (state_q != S_HOLD)) err_d = 1'b1;

    running_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= S_IDLE;
      ip_q           <= RESET_IP;
      mem_re_q       <= 1'b0;
      mem_addr_q     <= RESET_IP;
      inst_valid_q   <= 1'b0;
      inst_q         <= '0;
      inst_ip_q      <= RESET_IP;
      running_q      <= 1'b0;
      err_q          <= 1'b0;
      retired_q      <= '0;
      stop_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ip_q           <= ip_d;
      mem_re_q       <= mem_re_d;
      mem_addr_q     <= mem_addr_d;
      inst_valid_q   <= inst_valid_d;
      inst_q         <= inst_d;
      inst_ip_q      <= inst_ip_d;
      running_q      <= running_d;
      err_q          <= err_d;
      retired_q      <= retired_d;
      stop_pending_q <= stop_pending_d;
    end
  end

  assign mem_re       = mem_re_q;
  assign mem_addr     = mem_addr_q;
  assign inst_valid   = inst_valid_q;
  assign inst         = inst_q;
  assign inst_ip      = inst_ip_q;
  assign running      = running_q;
  assign err_spurious = err_q;
  assign retired      = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_mpu_ip_fetch.sv
// Directed bench for mpu_ip_fetch with a fetch scoreboard (expected address/data queue).
`default_nettype none

module tb_mpu_ip_fetch;

  localparam int RW = 3;
  localparam int RET_MAX = (1 << RW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          ctl_start, ctl_stop, ctl_ip_sel;
  logic [15:0]   ctl_ip;
  logic          ip_en, ip_load;
  logic [15:0]   ip_incr, ip_data;
  logic          mem_re;
  logic [15:0]   mem_addr;
  logic          mem_ack;
  logic [63:0]   mem_data;
  logic          inst_valid;
  logic [63:0]   inst;
  logic [15:0]   inst_ip;
  logic          running;
  logic          err_spurious;
  logic [RW-1:0] retired;

  always #5 sys_clk = ~sys_clk;

  mpu_ip_fetch #(.RESET_IP(16'h0000), .RETIRE_WIDTH(RW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .ctl_start(ctl_start), .ctl_stop(ctl_stop), .ctl_ip_sel(ctl_ip_sel), .ctl_ip(ctl_ip),
    .ip_en(ip_en), .ip_incr(ip_incr), .ip_load(ip_load), .ip_data(ip_data),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_ip(inst_ip),
    .running(running), .err_spurious(err_spurious), .retired(retired)
  );

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
  } fetch_t;

  fetch_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;
  int seq      = 1;
  int exp_ret  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_fetch(input logic [15:0] a);
    fetch_t f;
    f.addr = a;
    f.data = {32'hDEADBEEF, 32'(seq)};
    seq++;
    sb.push_back(f);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_re"}, 64'(mem_re), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'h0000);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst"}, inst, 64'd0);
    chk({tag, "_inst_ip"}, 64'(inst_ip), 64'h0000);
    chk({tag, "_running"}, 64'(running), 64'd0);
    chk({tag, "_err"}, 64'(err_spurious), 64'd0);
    chk({tag, "_retired"}, 64'(retired), 64'd0);
  endtask

  // Waits for the request, checks it against the scoreboard, then answers it.
  task automatic serve(input bit stop_in_wait, input bit spur_in_wait);
    fetch_t f;
    int k;
    k = 0;
    while (!mem_re && k < 20) begin
      tick;
      k++;
    end
    chk("mem_re_seen", 64'(mem_re), 64'd1);
    chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    f = sb.pop_front();
    chk("mem_addr", 64'(mem_addr), 64'(f.addr));
    tick;
    chk("mem_re_pulse", 64'(mem_re), 64'd0);
    if (stop_in_wait) begin
      ctl_stop = 1'b1;
      tick;
      ctl_stop = 1'b0;
    end
    if (spur_in_wait) begin
      ip_en = 1'b1;
      ip_incr = 16'h0010;
      tick;
      ip_en = 1'b0;
      ip_incr = 16'h0000;
      chk("err_spurious_set", 64'(err_spurious), 64'd1);
    end
    chk("inst_valid_wait", 64'(inst_valid), 64'd0);
    mem_ack = 1'b1;
    mem_data = f.data;
    tick;
    mem_ack = 1'b0;
    mem_data = '0;
    chk("inst_valid", 64'(inst_valid), 64'd1);
    chk("inst", inst, f.data);
    chk("inst_ip", 64'(inst_ip), 64'(f.addr));
    chk("running_hold", 64'(running), 64'd1);
  endtask

  task automatic commit(input logic [15:0] incr, input bit load, input logic [15:0] data,
                        input bit stop, input bit expect_fetch, input logic [15:0] next_addr);
    if (expect_fetch) push_fetch(next_addr);
    ip_en = 1'b1;
    ip_incr = incr;
    ip_load = load;
    ip_data = data;
    ctl_stop = stop;
    tick;
    ip_en = 1'b0;
    ip_incr = 16'h0000;
    ip_load = 1'b0;
    ip_data = 16'h0000;
    ctl_stop = 1'b0;
    exp_ret = (exp_ret < RET_MAX) ? exp_ret + 1 : RET_MAX;
    chk("commit_inst_valid", 64'(inst_valid), 64'd0);
    chk("commit_retired", 64'(retired), 64'(exp_ret));
    chk("commit_mem_re", 64'(mem_re), 64'(expect_fetch));
    chk("commit_running", 64'(running), 64'(expect_fetch));
  endtask

  task automatic start(input bit sel, input logic [15:0] a, input bit stop, input logic [15:0] exp_addr);
    push_fetch(exp_addr);
    ctl_start = 1'b1;
    ctl_ip_sel = sel;
    ctl_ip = a;
    ctl_stop = stop;
    tick;
    ctl_start = 1'b0;
    ctl_ip_sel = 1'b0;
    ctl_ip = 16'h0000;
    ctl_stop = 1'b0;
    exp_ret = 0;
    chk("start_mem_re", 64'(mem_re), 64'd1);
    chk("start_running", 64'(running), 64'd1);
    chk("start_err_clr", 64'(err_spurious), 64'd0);
    chk("start_retired_clr", 64'(retired), 64'd0);
  endtask

  initial begin
    fetch_t f;
    sys_rst_n = 1'b0;
    ctl_start = 1'b0; ctl_stop = 1'b0; ctl_ip_sel = 1'b0; ctl_ip = 16'h0000;
    ip_en = 1'b0; ip_incr = 16'h0000; ip_load = 1'b0; ip_data = 16'h0000;
    mem_ack = 1'b0; mem_data = '0;
    tick;
    tick;
    chk_reset_outputs("rst");
    sys_rst_n = 1'b1;
    tick;
    chk_reset_outputs("post_rst");

    // Start at 0x0100, then increment, jump, and 16-bit wrap.
    start(1'b1, 16'h0100, 1'b0, 16'h0100);
    serve(1'b0, 1'b0);
    commit(16'd6, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0106);
    serve(1'b0, 1'b0);
    commit(16'd0, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0040);
    serve(1'b0, 1'b0);
    commit(16'd0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 16'hFFFE);
    serve(1'b0, 1'b0);
    commit(16'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002);

    // Stop during WAIT: the instruction still arrives, then IDLE after its commit.
    serve(1'b1, 1'b0);
    commit(16'd2, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("idle_no_mem_re", 64'(mem_re), 64'd0);
    end

    // Start from RESET_IP; spurious commit in WAIT must leave ip untouched.
    start(1'b0, 16'h1234, 1'b0, 16'h0000);
    serve(1'b0, 1'b1);
    commit(16'd4, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004);
    chk("err_sticky", 64'(err_spurious), 64'd1);
    serve(1'b0, 1'b0);
    commit(16'd1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

    // Start and stop together: start wins, stop is remembered.
    start(1'b1, 16'h0200, 1'b1, 16'h0200);
    serve(1'b0, 1'b0);
    commit(16'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);

    // Zero-increment refetch and retired-counter saturation.
    start(1'b1, 16'h0200, 1'b0, 16'h0200);
    for (int i = 0; i < 9; i++) begin
      serve(1'b0, 1'b0);
      commit(16'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0200);
    end
    chk("retired_saturated", 64'(retired), 64'(RET_MAX));

    // Reset in WAIT, with the acknowledge arriving afterwards.
    chk("pre_rst_mem_re", 64'(mem_re), 64'd1);
    f = sb.pop_front();
    chk("pre_rst_mem_addr", 64'(mem_addr), 64'(f.addr));
    tick;
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    mem_ack = 1'b1;
    mem_data = 64'hCAFEF00D_12345678;
    tick;
    mem_ack = 1'b0;
    sys_rst_n = 1'b1;
    tick;
    chk_reset_outputs("after_drop");
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    chk("idle_ack_ignored", 64'(inst_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
